// File: rtl/spmv_mem_responder.sv
// spmv_mem_responder
//   Memory-side responder for a PE memory port. Loads and stores are accepted
//   every cycle they are presented. A load reads a local word-addressed RAM,
//   travels a fixed-latency valid pipeline, lands in an in-order response FIFO
//   and is returned with its 3-bit tag. Stores write the RAM and return nothing.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   req_mem_ld/_st        one-cycle load / store request strobes
//   req_mem_addr          byte address; word index = addr[MEM_LOG2+2:3]
//   req_mem_d_or_tag      store data, or load tag in [2:0]
//   req_mem_stall         registered advisory back-pressure to the requester
//   rsp_mem_push          registered response valid
//   rsp_mem_tag/_q        tag and data of the returning load
//   rsp_mem_stall         requester cannot accept a response this cycle
//   ld_count/st_count     accepted load / store counters (wrapping)
//   err                   sticky: ld+st collision or response FIFO overflow
module spmv_mem_responder #(
  parameter int unsigned MEM_LOG2  = 10,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned RSP_DEPTH = 16,
  parameter int unsigned SKID      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_mem_ld,
  input  logic        req_mem_st,
  input  logic [47:0] req_mem_addr,
  input  logic [63:0] req_mem_d_or_tag,
  output logic        req_mem_stall,
  output logic        rsp_mem_push,
  output logic [2:0]  rsp_mem_tag,
  output logic [63:0] rsp_mem_q,
  input  logic        rsp_mem_stall,
  output logic [31:0] ld_count,
  output logic [31:0] st_count,
  output logic        err
);

  localparam int unsigned WORDS = 1 << MEM_LOG2;
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic [MEM_LOG2-1:0] idx;
  logic                ld_ok;
  logic                collide;
  logic                unused_addr;

  assign idx         = req_mem_addr[MEM_LOG2+2:3];
  assign ld_ok       = req_mem_ld & ~req_mem_st;
  assign collide     = req_mem_ld & req_mem_st;
  assign unused_addr = ^{req_mem_addr[47:MEM_LOG2+3], req_mem_addr[2:0]};

  // --------------------------------------------------------------------------
  // Backing RAM (contents survive reset). Asynchronous read so a load
  // accepted the cycle after a store sees the stored value.
  // --------------------------------------------------------------------------
  logic [63:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (req_mem_st) begin
      mem[idx] <= req_mem_d_or_tag;
    end
  end

  // --------------------------------------------------------------------------
  // Load pipeline: only the valids are reset, payload simply shifts.
  // --------------------------------------------------------------------------
  logic [LATENCY-1:0] pipe_valid;
  logic [LATENCY-1:0] valid_next;
  logic [2:0]         pipe_tag  [LATENCY];
  logic [63:0]        pipe_data [LATENCY];

  always_comb begin
    valid_next    = '0;
    valid_next[0] = ld_ok;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      valid_next[i] = pipe_valid[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid <= valid_next;
    end
  end

  always_ff @(posedge clk) begin
    pipe_tag[0]  <= req_mem_d_or_tag[2:0];
    pipe_data[0] <= mem[idx];
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pipe_tag[i]  <= pipe_tag[i-1];
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  // --------------------------------------------------------------------------
  // Response FIFO
  // --------------------------------------------------------------------------
  logic [2:0]       fifo_tag  [RSP_DEPTH];
  logic [63:0]      fifo_data [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             exit_v;
  logic             full;
  logic             pop;
  logic             push;
  logic             overflow;

  assign exit_v   = pipe_valid[LATENCY-1];
  assign full     = (count == CNT_W'(RSP_DEPTH));
  assign pop      = (count != '0) && !rsp_mem_stall;
  // A pop in the same cycle frees the head slot, so a full FIFO still
  // absorbs the exiting load.
  assign push     = exit_v && (!full || pop);
  assign overflow = exit_v && full && !pop;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (!push && pop) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_tag[wr_ptr]  <= pipe_tag[LATENCY-1];
      fifo_data[wr_ptr] <= pipe_data[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Credit tracking: every load in the pipeline already owns a FIFO slot.
  // Stall is computed from next-state occupancy so it is aligned with the
  // register it is loaded into. RSP_DEPTH - used <= SKID + 1 is rewritten
  // additively to stay unsigned-safe.
  // --------------------------------------------------------------------------
  logic [31:0] valid_cnt;
  logic [31:0] used_next;
  logic        stall_next;

  always_comb begin
    valid_cnt = '0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      valid_cnt = valid_cnt + 32'(valid_next[i]);
    end
  end

  assign used_next  = 32'(count_next) + valid_cnt;
  assign stall_next = (used_next + SKID + 32'd1) >= RSP_DEPTH;

  // --------------------------------------------------------------------------
  // Registered outputs, counters and sticky error
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_mem_stall <= 1'b0;
      rsp_mem_push  <= 1'b0;
      rsp_mem_tag   <= '0;
      rsp_mem_q     <= '0;
      ld_count      <= '0;
      st_count      <= '0;
      err           <= 1'b0;
    end else begin
      req_mem_stall <= stall_next;
      rsp_mem_push  <= pop;
      if (pop) begin
        rsp_mem_tag <= fifo_tag[rd_ptr];
        rsp_mem_q   <= fifo_data[rd_ptr];
      end
      if (ld_ok) begin
        ld_count <= ld_count + 32'd1;
      end
      if (req_mem_st) begin
        st_count <= st_count + 32'd1;
      end
      if (collide || overflow) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spmv_mem_responder.sv
module tb_spmv_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_mem_ld = 1'b0;
  logic        req_mem_st = 1'b0;
  logic [47:0] req_mem_addr = '0;
  logic [63:0] req_mem_d_or_tag = '0;
  logic        req_mem_stall;
  logic        rsp_mem_push;
  logic [2:0]  rsp_mem_tag;
  logic [63:0] rsp_mem_q;
  logic        rsp_mem_stall = 1'b0;
  logic [31:0] ld_count;
  logic [31:0] st_count;
  logic        err;

  spmv_mem_responder #(
    .MEM_LOG2 (10),
    .LATENCY  (4),
    .RSP_DEPTH(16),
    .SKID     (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_mem_ld      (req_mem_ld),
    .req_mem_st      (req_mem_st),
    .req_mem_addr    (req_mem_addr),
    .req_mem_d_or_tag(req_mem_d_or_tag),
    .req_mem_stall   (req_mem_stall),
    .rsp_mem_push    (rsp_mem_push),
    .rsp_mem_tag     (rsp_mem_tag),
    .rsp_mem_q       (rsp_mem_q),
    .rsp_mem_stall   (rsp_mem_stall),
    .ld_count        (ld_count),
    .st_count        (st_count),
    .err             (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor, sampled on the falling edge
  logic [2:0]  obs_tag [$];
  logic [63:0] obs_q   [$];
  int          obs_cyc [$];

  always @(negedge clk) begin
    if (rst && rsp_mem_push) begin
      obs_tag.push_back(rsp_mem_tag);
      obs_q.push_back(rsp_mem_q);
      obs_cyc.push_back(cyc);
    end
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_ld   = '0;
  logic [31:0] exp_st   = '0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] stream_data(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i * 32'h1111);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_tag.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic do_store(input logic [47:0] a, input logic [63:0] dat);
    req_mem_st       = 1'b1;
    req_mem_addr     = a;
    req_mem_d_or_tag = dat;
    tick();
    req_mem_st = 1'b0;
    exp_st     = exp_st + 32'd1;
  endtask

  task automatic do_load(input logic [47:0] a, input logic [2:0] tg);
    req_mem_ld       = 1'b1;
    req_mem_addr     = a;
    req_mem_d_or_tag = {61'h1FFF_FFFF_FFFF_FFF0, tg};
    tick();
    req_mem_ld = 1'b0;
    exp_ld     = exp_ld + 32'd1;
  endtask

  task automatic wait_pushes(input int n, input int budget, output bit ok);
    int i = 0;
    while (obs_tag.size() < n && i < budget) begin
      tick();
      i++;
    end
    ok = (obs_tag.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_checks++; if (rsp_mem_push !== 1'b0) begin n_fail++; $display("FAIL reset_push: got %b expected 0", rsp_mem_push); end
    n_checks++; if (req_mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", req_mem_stall); end
    n_checks++; if (rsp_mem_tag !== 3'd0) begin n_fail++; $display("FAIL reset_tag: got %0d expected 0", rsp_mem_tag); end
    n_checks++; if (rsp_mem_q !== 64'd0) begin n_fail++; $display("FAIL reset_q: got %h expected 0", rsp_mem_q); end
    n_checks++; if (ld_count !== 32'd0 || st_count !== 32'd0) begin n_fail++; $display("FAIL reset_counts: got ld=%0d st=%0d expected 0/0", ld_count, st_count); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_round_trip();
    int t0;
    bit ok;
    clear_obs();
    do_store(48'h40, 64'hDEADBEEF_00000001);
    do_load(48'h40, 3'd3);
    t0 = cyc;
    wait_pushes(1, 20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rt_timeout: got 0 responses expected 1"); end
    repeat (5) tick();
    n_checks++; if (obs_tag.size() != 1) begin n_fail++; $display("FAIL rt_count: got %0d responses expected 1", obs_tag.size()); end
    if (obs_tag.size() >= 1) begin
      n_checks++; if (obs_tag[0] !== 3'd3) begin n_fail++; $display("FAIL rt_tag: got %0d expected 3", obs_tag[0]); end
      n_checks++; if (obs_q[0] !== 64'hDEADBEEF_00000001) begin n_fail++; $display("FAIL rt_q: got %h expected deadbeef00000001", obs_q[0]); end
      n_checks++; if (obs_cyc[0] != t0 + 5) begin n_fail++; $display("FAIL rt_latency: got cycle %0d expected %0d", obs_cyc[0], t0 + 5); end
    end
    n_checks++; if (ld_count !== 32'd1) begin n_fail++; $display("FAIL rt_ld_count: got %0d expected 1", ld_count); end
    n_checks++; if (st_count !== 32'd1) begin n_fail++; $display("FAIL rt_st_count: got %0d expected 1", st_count); end
  endtask

  task automatic test_alias();
    bit ok;
    clear_obs();
    do_store(48'h2000, 64'h55);
    do_load(48'h0005, 3'd1);
    wait_pushes(1, 20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL alias_timeout: got 0 responses expected 1"); end
    if (ok) begin
      n_checks++; if (obs_tag[0] !== 3'd1) begin n_fail++; $display("FAIL alias_tag: got %0d expected 1", obs_tag[0]); end
      n_checks++; if (obs_q[0] !== 64'h55) begin n_fail++; $display("FAIL alias_q: got %h expected 55", obs_q[0]); end
    end
  endtask

  task automatic test_streaming();
    bit ok;
    bit stall_seen = 1'b0;
    for (int i = 0; i < 12; i++) do_store(48'h1000 + 48'(i * 8), stream_data(i));
    tick();
    clear_obs();
    for (int i = 0; i < 12; i++) begin
      do_load(48'h1000 + 48'(i * 8), 3'(i % 8));
      stall_seen = stall_seen | req_mem_stall;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      stall_seen = stall_seen | req_mem_stall;
    end
    wait_pushes(12, 20, ok);
    n_checks++; if (obs_tag.size() != 12) begin n_fail++; $display("FAIL stream_count: got %0d responses expected 12", obs_tag.size()); end
    n_checks++; if (stall_seen !== 1'b0) begin n_fail++; $display("FAIL stream_stall: got stall=1 expected 0"); end
    if (obs_tag.size() == 12) begin
      n_checks++; if (obs_cyc[11] - obs_cyc[0] != 11) begin n_fail++; $display("FAIL stream_consecutive: got span %0d expected 11", obs_cyc[11] - obs_cyc[0]); end
      for (int i = 0; i < 12; i++) begin
        n_checks++;
        if (obs_tag[i] !== 3'(i % 8) || obs_q[i] !== stream_data(i)) begin
          n_fail++;
          $display("FAIL stream_rsp%0d: got tag=%0d q=%h expected tag=%0d q=%h", i, obs_tag[i], obs_q[i], i % 8, stream_data(i));
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    int  issued = 0;
    int  drop_ticks = 0;
    bit  ok;
    clear_obs();
    rsp_mem_stall = 1'b1;
    while (issued < 20) begin
      do_load(48'h1000 + 48'((issued % 12) * 8), 3'(issued % 8));
      issued++;
      if (req_mem_stall) break;
    end
    n_checks++; if (issued != 13) begin n_fail++; $display("FAIL bp_threshold: got stall after %0d loads expected 13", issued); end
    do_load(48'h1000 + 48'((issued % 12) * 8), 3'(issued % 8));
    issued++;
    do_load(48'h1000 + 48'((issued % 12) * 8), 3'(issued % 8));
    issued++;
    repeat (6) tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL bp_err: got %b expected 0", err); end
    n_checks++; if (req_mem_stall !== 1'b1) begin n_fail++; $display("FAIL bp_stall_held: got %b expected 1", req_mem_stall); end
    n_checks++; if (obs_tag.size() != 0) begin n_fail++; $display("FAIL bp_frozen: got %0d responses expected 0", obs_tag.size()); end
    rsp_mem_stall = 1'b0;
    while (req_mem_stall && drop_ticks < 10) begin
      tick();
      drop_ticks++;
    end
    n_checks++; if (drop_ticks != 3) begin n_fail++; $display("FAIL bp_release: got stall drop after %0d cycles expected 3", drop_ticks); end
    wait_pushes(issued, 40, ok);
    n_checks++; if (obs_tag.size() != 15) begin n_fail++; $display("FAIL bp_count: got %0d responses expected 15", obs_tag.size()); end
    for (int i = 0; i < 15 && i < obs_tag.size(); i++) begin
      n_checks++;
      if (obs_tag[i] !== 3'(i % 8) || obs_q[i] !== stream_data(i % 12)) begin
        n_fail++;
        $display("FAIL bp_rsp%0d: got tag=%0d q=%h expected tag=%0d q=%h", i, obs_tag[i], obs_q[i], i % 8, stream_data(i % 12));
      end
    end
  endtask

  task automatic test_ld_st_error();
    bit ok;
    clear_obs();
    req_mem_ld       = 1'b1;
    req_mem_st       = 1'b1;
    req_mem_addr     = 48'h80;
    req_mem_d_or_tag = 64'd7;
    tick();
    req_mem_ld = 1'b0;
    req_mem_st = 1'b0;
    exp_st     = exp_st + 32'd1;
    repeat (10) tick();
    n_checks++; if (obs_tag.size() != 0) begin n_fail++; $display("FAIL collide_rsp: got %0d responses expected 0", obs_tag.size()); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL collide_err: got %b expected 1", err); end
    n_checks++; if (ld_count !== exp_ld) begin n_fail++; $display("FAIL collide_ld_count: got %0d expected %0d", ld_count, exp_ld); end
    n_checks++; if (st_count !== exp_st) begin n_fail++; $display("FAIL collide_st_count: got %0d expected %0d", st_count, exp_st); end
    do_load(48'h80, 3'd2);
    wait_pushes(1, 20, ok);
    n_checks++; if (!ok || obs_q[0] !== 64'd7) begin n_fail++; $display("FAIL collide_ram: got q=%h expected 7", ok ? obs_q[0] : 64'hx); end
  endtask

  task automatic test_reset_midflight();
    int t0;
    bit ok;
    clear_obs();
    do_load(48'h1000, 3'd4);
    do_load(48'h1008, 3'd5);
    do_load(48'h1010, 3'd6);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_ld = '0;
    exp_st = '0;
    repeat (12) tick();
    n_checks++; if (obs_tag.size() != 0) begin n_fail++; $display("FAIL midrst_rsp: got %0d responses expected 0", obs_tag.size()); end
    n_checks++; if (ld_count !== 32'd0 || st_count !== 32'd0) begin n_fail++; $display("FAIL midrst_counts: got ld=%0d st=%0d expected 0/0", ld_count, st_count); end
    n_checks++; if (req_mem_stall !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got stall=%b err=%b expected 0/0", req_mem_stall, err); end
    do_load(48'h80, 3'd5);
    t0 = cyc;
    wait_pushes(1, 20, ok);
    n_checks++;
    if (!ok || obs_tag[0] !== 3'd5 || obs_q[0] !== 64'd7 || obs_cyc[0] != t0 + 5) begin
      n_fail++;
      $display("FAIL midrst_new_load: got ok=%0d tag=%0d q=%h cyc=%0d expected tag=5 q=7 cyc=%0d",
               ok, ok ? obs_tag[0] : 3'hx, ok ? obs_q[0] : 64'hx, ok ? obs_cyc[0] : -1, t0 + 5);
    end
    n_checks++; if (ld_count !== 32'd1) begin n_fail++; $display("FAIL midrst_ld_count: got %0d expected 1", ld_count); end
  endtask

  task automatic test_overflow();
    bit ok;
    tick();
    clear_obs();
    rsp_mem_stall = 1'b1;
    for (int i = 0; i < 20; i++) do_load(48'h1000 + 48'((i % 12) * 8), 3'(i % 8));
    repeat (8) tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b expected 1", err); end
    rsp_mem_stall = 1'b0;
    wait_pushes(16, 40, ok);
    repeat (5) tick();
    n_checks++; if (obs_tag.size() != 16) begin n_fail++; $display("FAIL ovf_count: got %0d responses expected 16", obs_tag.size()); end
    for (int i = 0; i < 16 && i < obs_tag.size(); i++) begin
      n_checks++;
      if (obs_tag[i] !== 3'(i % 8) || obs_q[i] !== stream_data(i % 12)) begin
        n_fail++;
        $display("FAIL ovf_rsp%0d: got tag=%0d q=%h expected tag=%0d q=%h", i, obs_tag[i], obs_q[i], i % 8, stream_data(i % 12));
      end
    end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", err); end
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_alias();
    test_streaming();
    test_back_pressure();
    test_ld_st_error();
    test_reset_midflight();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spmv_mem_responder.md
Name: spmv_mem_responder

Overview:
- Memory-side responder for the PE memory port. It accepts the load and store requests a PE issues and returns tagged load responses.
- Backed by a local word-addressed RAM with a fixed-latency read pipeline and an in-order response FIFO.
- Serves as the synthesizable bench/emulation target for PE memory traffic: decoder fetches (tag bit0=0), x-vector fetches (tag bit0=1), and result stores.

Parameters:
- MEM_LOG2, 10, log2 of RAM depth in 64-bit words.
- LATENCY, 4, cycles from load accept to response-FIFO write; minimum 1.
- RSP_DEPTH, 16, response FIFO entries; must be ≥ LATENCY+4.
- SKID, 2, credits held in reserve when stall is raised; covers the requester's registered issue path.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_mem_ld  in  1  load request, one cycle per request.
- req_mem_st  in  1  store request, one cycle per request.
- req_mem_addr  in  48  byte address; word index = addr[MEM_LOG2+2:3].
- req_mem_d_or_tag  in  64  store data, or load tag in [2:0] (upper bits ignored).
- req_mem_stall  out  1  advisory back-pressure, registered.
- rsp_mem_push  out  1  response valid, registered.
- rsp_mem_tag  out  3  tag of the returning load.
- rsp_mem_q  out  64  load data.
- rsp_mem_stall  in  1  requester cannot take a response this cycle.
- ld_count  out  32  accepted loads, wraps at 2^32.
- st_count  out  32  accepted stores, wraps at 2^32.
- err  out  1  sticky: ld+st together, or response FIFO overflow.

Behaviour:
- Reset (rst=0, asynchronous):
  - Clears req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q, ld_count, st_count, err, pipeline valids, FIFO pointers and count.
  - RAM contents are not reset.
  - Reset mid-operation discards all in-flight loads; no response is emitted for them.
- Accept:
  - Every cycle with req_mem_ld or req_mem_st high is accepted. req_mem_stall is advisory, not a drop condition.
  - addr[2:0] and addr[47:MEM_LOG2+3] are ignored, so high addresses alias.
- Store:
  - RAM[idx] <= d_or_tag at the accept edge; st_count+1.
  - A load accepted in the next cycle reads the new value.
  - Stores produce no response and consume no credit.
- ld and st in the same cycle: perform the store, drop the load, set err, increment st_count only.
- Load:
  - RAM is read at accept. Data and tag then travel a LATENCY-stage valid pipeline and are written to the FIFO tail on exit.
  - ld_count+1.
- Ordering: responses are strictly in load-accept order; tags are never reordered or merged.
- Response output:
  - Each cycle, if the FIFO is non-empty and rsp_mem_stall=0, pop the head. Next cycle: rsp_mem_push=1 with that tag and data.
  - Otherwise rsp_mem_push=0 next cycle, and rsp_mem_tag/rsp_mem_q hold their last values.
  - rsp_mem_stall=1 freezes the FIFO; no response is lost.
- Latency: an unloaded load accepted at edge T gives rsp_mem_push=1 at cycle T+LATENCY+1.
- Credits:
  - used = FIFO count + valid pipeline stages.
  - req_mem_stall <= (RSP_DEPTH - used) <= SKID + 1, evaluated each cycle using the next-state used.
  - Deasserts the cycle after room returns.
- Overflow: a pipeline exit while the FIFO is full sets err; that response is discarded. A requester that honours stall within SKID cycles never reaches this.
- Simultaneous FIFO push and pop when full: legal. The pop frees the slot, so no overflow.
- Counters wrap silently.
- err clears only on reset.

Test Plan:
- Store/load round trip: reset, store 0xDEADBEEF_00000001 at addr 0x40, load addr 0x40 tag 3 the next cycle → one push at T+5 with tag=3, q=0xDEADBEEF_00000001; ld_count=1, st_count=1.
- Aliasing and alignment: store 0x55 to addr 0x2000, load addr 0x0005 tag 1 → q=0x55. With MEM_LOG2=10, word 0 aliases and low bits are ignored.
- Streaming order: 12 back-to-back loads, tags 0..7,0..3, distinct addresses pre-stored → 12 consecutive pushes in issue order with matching data, req_mem_stall never high.
- Back-pressure: hold rsp_mem_stall=1 and issue loads until req_mem_stall rises → rises when used ≥ 13 (RSP_DEPTH=16). Issue 2 more skid loads → err=0. Release rsp_mem_stall → all loads return in order, stall drops once used ≤ 12.
- Error: ld+st in the same cycle at addr 0x80, data 7 → no response, RAM[0x80]=7, err=1, ld_count unchanged. Then overfill by ignoring stall → err stays 1.
- Reset mid-flight: 3 loads in the pipeline, pulse rst low for 1 cycle → no pushes afterwards, counters=0, req_mem_stall=0; a new load responds normally.
